// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO with 1-cycle read latency into a valid/ready stream,
// framing every BURST_LEN delivered words with m_last.
module fifo_stream_reader #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fifo_empty,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              flush,
    output logic              idle
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    // Handshake: a word transfers on every rising edge where m_valid and m_ready are both 1;
    // once m_valid rises, m_data/m_last hold until that transfer, and m_valid only falls after it.

    logic [1:0]        occ;
    logic              rd_inflight_q;
    logic [BW-1:0]     beat;
    logic [DATA_W-1:0] buf_mem [2];
    logic              head;
    logic              tail;
    logic              pop;
    logic              capture;
    logic [2:0]        depth;

    assign pop     = m_valid & m_ready;
    assign capture = rd_inflight_q & ~flush;

    // Slots still free after this cycle's pop must cover the word already in flight plus the new one.
    assign depth     = {1'b0, occ} + {2'b0, rd_inflight_q} - {2'b0, pop};
    assign fifo_read = nrst & ~flush & ~fifo_empty & (depth <= 3'd1);

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_mem[head];
    assign m_last  = m_valid & (beat == LAST_BEAT);
    assign idle    = (occ == 2'd0) & ~rd_inflight_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            occ           <= 2'd0;
            rd_inflight_q <= 1'b0;
            beat          <= '0;
            head          <= 1'b0;
            tail          <= 1'b0;
            buf_mem[0]    <= '0;
            buf_mem[1]    <= '0;
        end else if (flush) begin
            occ           <= 2'd0;
            rd_inflight_q <= 1'b0;
            beat          <= '0;
            head          <= 1'b0;
            tail          <= 1'b0;
        end else begin
            rd_inflight_q <= fifo_read;
            if (capture) begin
                buf_mem[tail] <= fifo_rdata;
                tail          <= ~tail;
            end
            if (pop) begin
                head <= ~head;
                beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
            end
            occ <= occ + {1'b0, capture} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised bench for fifo_stream_reader: a queue-level model of the FIFO, skid buffer
// and burst counter is compared against the DUT every cycle, plus literal scenario checks.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          nrst;
    logic          fifo_empty;
    logic          fifo_read;
    logic [DW-1:0] fifo_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          flush;
    logic          idle;

    fifo_stream_reader #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .nrst(nrst), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
        .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .flush(flush), .idle(idle)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // source FIFO contents and model of words the stream still owes
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic          m_inflight;
    logic [DW-1:0] m_inflight_word;
    int            m_beat;
    logic          gap;

    // occupancy reconstructed from observed DUT handshakes
    int dut_occ;
    int dut_inflight;

    // observation records
    logic [DW-1:0] got_q[$];
    logic          got_last_q[$];
    int            cyc;
    int            rd_cnt;
    int            first_rd_cyc;
    int            first_val_cyc;
    int            last_pop_cyc;
    logic          samp_valid;
    logic          samp_idle;
    logic [DW-1:0] samp_data;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_last_q.delete();
        rd_cnt        = 0;
        first_rd_cyc  = -1;
        first_val_cyc = -1;
        last_pop_cyc  = -1;
    endtask

    // One clock cycle: inputs already driven, outputs checked at the falling edge.
    task automatic step();
        logic          exp_valid, exp_last, exp_idle, exp_read, pop;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] rdata_next;
        int            depth;
        fifo_empty = gap || (src_q.size() == 0);
        @(negedge clk);
        cyc++;
        if (!nrst) begin
            exp_q.delete();
            m_inflight   = 1'b0;
            m_beat       = 0;
            dut_occ      = 0;
            dut_inflight = 0;
        end
        exp_valid = (exp_q.size() != 0);
        exp_data  = exp_valid ? exp_q[0] : '0;
        exp_last  = exp_valid && (m_beat == BL - 1);
        exp_idle  = (exp_q.size() == 0) && !m_inflight;
        pop       = exp_valid && m_ready;
        depth     = exp_q.size() + int'(m_inflight) - int'(pop);
        exp_read  = nrst && !flush && !fifo_empty && (depth <= 1);

        check("m_valid", {31'b0, m_valid}, {31'b0, exp_valid});
        check("m_last", {31'b0, m_last}, {31'b0, exp_last});
        check("idle", {31'b0, idle}, {31'b0, exp_idle});
        check("fifo_read", {31'b0, fifo_read}, {31'b0, exp_read});
        if (exp_valid || !nrst) check("m_data", m_data, exp_data);
        check("occ_bound", {31'b0, (dut_occ + dut_inflight) <= 2}, 32'd1);

        samp_valid = m_valid;
        samp_idle  = idle;
        samp_data  = m_data;
        if (fifo_read) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (m_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            got_last_q.push_back(m_last);
            last_pop_cyc = cyc;
        end

        if (flush) begin
            dut_occ      = 0;
            dut_inflight = 0;
        end else begin
            dut_occ      = dut_occ + dut_inflight - int'(m_valid && m_ready);
            dut_inflight = int'(fifo_read);
        end

        if (flush) begin
            exp_q.delete();
            m_beat = 0;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                m_beat = (m_beat + 1) % BL;
            end
            if (m_inflight) exp_q.push_back(m_inflight_word);
        end
        m_inflight = exp_read;
        if (exp_read && src_q.size() > 0) m_inflight_word = src_q[0];

        rdata_next = $urandom;
        if (fifo_read && src_q.size() > 0) rdata_next = src_q.pop_front();
        @(posedge clk);
        #1;
        fifo_rdata = rdata_next;
    endtask

    task automatic do_reset();
        nrst    = 1'b0;
        flush   = 1'b0;
        gap     = 1'b0;
        m_ready = 1'b0;
        repeat (3) step();
        src_q.delete();
        nrst = 1'b1;
        clear_obs();
    endtask

    task automatic run_until(input int n, input int max_cyc, input string name);
        int k = 0;
        while (got_q.size() < n && k < max_cyc) begin
            step();
            k++;
        end
        check({name, "_timeout"}, {31'b0, got_q.size() >= n}, 32'd1);
    endtask

    task automatic load_seq(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) src_q.push_back(base + DW'(i));
    endtask

    int n_last;

    initial begin
        nrst       = 1'b0;
        flush      = 1'b0;
        gap        = 1'b0;
        m_ready    = 1'b0;
        fifo_rdata = '0;
        fifo_empty = 1'b1;
        m_inflight = 1'b0;
        m_inflight_word = '0;
        m_beat     = 0;
        dut_occ    = 0;
        dut_inflight = 0;
        cyc        = 0;
        clear_obs();

        // reset with a non-empty FIFO: no reads, stream quiet
        load_seq(4, 32'h1);
        m_ready = 1'b1;
        repeat (5) step();
        check("rst_no_read", rd_cnt, 0);
        check("rst_idle", {31'b0, samp_idle}, 32'd1);
        check("rst_data", samp_data, 32'd0);
        do_reset();

        // full-rate drain of 0x1..0x20
        load_seq(32, 32'h1);
        m_ready = 1'b1;
        run_until(32, 60, "drain");
        check("latency", first_val_cyc - first_rd_cyc, 2);
        check("rate", last_pop_cyc - first_val_cyc, 31);
        check("drain_w0", got_q[0], 32'h1);
        check("drain_w31", got_q[31], 32'h20);
        n_last = 0;
        for (int i = 0; i < 32; i++) if (got_last_q[i]) n_last++;
        check("drain_nlast", n_last, 2);
        check("drain_last_a", {31'b0, got_last_q[15]}, 32'd1);
        check("drain_last_b", {31'b0, got_last_q[31]}, 32'd1);
        do_reset();

        // backpressure: exactly two reads, head word held, clean restart
        load_seq(8, 32'h1);
        m_ready = 1'b0;
        repeat (10) step();
        check("bp_reads", rd_cnt, 2);
        check("bp_hold", samp_data, 32'h1);
        check("bp_valid", {31'b0, samp_valid}, 32'd1);
        clear_obs();
        m_ready = 1'b1;
        run_until(8, 20, "bp");
        for (int i = 0; i < 8; i++) check("bp_order", got_q[i], 32'(i + 1));
        check("bp_nogap", last_pop_cyc - first_val_cyc, 7);
        do_reset();

        // toggling ready over 32 random words
        for (int i = 0; i < 32; i++) src_q.push_back($urandom);
        begin
            logic [DW-1:0] ref_q[$];
            ref_q = src_q;
            for (int k = 0; k < 120 && got_q.size() < 32; k++) begin
                m_ready = k[0];
                step();
            end
            check("tog_count", got_q.size(), 32);
            for (int i = 0; i < 32 && i < got_q.size(); i++) check("tog_word", got_q[i], ref_q[i]);
        end
        do_reset();

        // flush mid-burst after beat 5 with a word in flight
        load_seq(48, 32'h100);
        m_ready = 1'b1;
        run_until(6, 30, "fl_pre");
        m_ready = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("fl_valid", {31'b0, samp_valid}, 32'd0);
        check("fl_idle", {31'b0, samp_idle}, 32'd1);
        clear_obs();
        m_ready = 1'b1;
        run_until(17, 40, "fl_post");
        n_last = 0;
        for (int i = 0; i < 15; i++) if (got_last_q[i]) n_last++;
        check("fl_nolast_early", n_last, 0);
        check("fl_last16", {31'b0, got_last_q[15]}, 32'd1);
        do_reset();

        // FIFO empty gap after beat 7: beat count carries over the gap
        load_seq(60, 32'h200);
        m_ready = 1'b1;
        run_until(8, 30, "gap_pre");
        gap    = 1'b1;
        rd_cnt = 0;
        repeat (10) step();
        check("gap_noread", rd_cnt, 0);
        gap = 1'b0;
        run_until(20, 40, "gap_post");
        n_last = 0;
        for (int i = 0; i < 16; i++) if (got_last_q[i]) n_last++;
        check("gap_nlast", n_last, 1);
        check("gap_last16", {31'b0, got_last_q[15]}, 32'd1);
        check("gap_w15", got_q[15], 32'h20f);
        do_reset();

        // random ready, empty gaps and flushes
        for (int i = 0; i < 200; i++) src_q.push_back($urandom);
        for (int k = 0; k < 400; k++) begin
            m_ready = 1'($urandom_range(0, 1));
            gap     = ($urandom_range(0, 7) == 0);
            flush   = ($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0;
        gap   = 1'b0;
        // mid-stream asynchronous reset
        m_ready = 1'b1;
        load_seq(20, 32'h300);
        repeat (3) step();
        do_reset();
        check("end_idle", {31'b0, samp_idle}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
